// File: rtl/fetch_exec_sequencer.sv
// rtl/fetch_exec_sequencer.sv - two-phase fetch/execute sequencer with fetch timeout fault
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   run, step          free-run level / single-instruction pulse (step honoured only in HALT)
//   instr_in[7:0]      program memory data {opcode, operand}, qualified by instr_valid in FETCH
//   alu_carry/zero     ALU results for the instruction in EXEC, written when flag_we=1
//   fault_clr          clears the sticky fault
//   fetch_req          high in FETCH
//   dec_addr[6:0]      {opcode, carry_flag, zero_flag, phase} to the control-word decoder
//   phase              1 in EXEC
//   operand[3:0]       IR[3:0]
//   halted             high in HALT
//   fault              sticky fetch-timeout flag
//   instr_count        retired-instruction counter, wraps

module fetch_exec_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               step,
    input  logic [7:0]         instr_in,
    input  logic               instr_valid,
    input  logic               alu_carry,
    input  logic               alu_zero,
    input  logic               flag_we,
    input  logic               fault_clr,
    output logic               fetch_req,
    output logic [6:0]         dec_addr,
    output logic               phase,
    output logic [3:0]         operand,
    output logic               halted,
    output logic               fault,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    // The wait counter holds the number of empty FETCH cycles already spent,
    // so the TIMEOUT-th empty cycle is the one where it equals TIMEOUT-1.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [7:0]         ir_q, ir_d;
    logic [1:0]         flags_q, flags_d;   // {carry, zero}
    logic               fault_q, fault_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [7:0]         wait_q, wait_d;
    logic               timeout;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        count_d = count_q;
        wait_d  = wait_q;
        timeout = 1'b0;

        case (state_q)
            S_HALT: begin
                if (!fault_q && (run || step)) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr_in;
                    wait_d  = 8'd0;
                    state_d = S_EXEC;
                end else if (wait_q == WAIT_LAST) begin
                    timeout = 1'b1;
                    wait_d  = 8'd0;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_EXEC: begin
                if (flag_we) begin
                    flags_d = {alu_carry, alu_zero};
                end
                count_d = count_q + COUNT_W'(1);
                state_d = run ? S_FETCH : S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        // A timeout in the same cycle as fault_clr keeps the fault set.
        fault_d = timeout | (fault_q & ~fault_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_HALT;
            ir_q    <= 8'h00;
            flags_q <= 2'b00;
            fault_q <= 1'b0;
            count_q <= '0;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
            fault_q <= fault_d;
            count_q <= count_d;
            wait_q  <= wait_d;
        end
    end

    // Status outputs decode directly from the state flop, so they change only on clock edges.
    assign fetch_req   = (state_q == S_FETCH);
    assign phase       = (state_q == S_EXEC);
    assign halted      = (state_q == S_HALT);
    assign dec_addr    = {ir_q[7:4], flags_q, phase};
    assign operand     = ir_q[3:0];
    assign fault       = fault_q;
    assign instr_count = count_q;

endmodule
